// File: rtl/dvi_mode_sequencer.sv
// rtl/dvi_mode_sequencer.sv - frame-synchronous output gate and demo-mode scheduler for the DVI timing core
// Optional auto-cycle timer is built only when DVI_SEQ_AUTO_EN is defined.
module dvi_mode_sequencer #(
    parameter int WARMUP_FRAMES = 4,
    parameter int AUTO_FRAMES   = 300,
    parameter int NUM_MODES     = 4
) (
    input  logic       i_clk_dot,
    input  logic       i_reset_n,
    input  logic       i_pll_lock,
    input  logic       i_vga_vs,
    input  logic       i_btn_step,
    input  logic       i_auto_en,
    output logic [1:0] o_mode_sel,
    output logic       o_mode_bit,
    output logic       o_color_3b,
    output logic       o_out_en,
    output logic [1:0] o_seq_state
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_WARM = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_lock_m;
    logic       r_lock_s;
    logic       r_vs_q;
    logic       r_frame_start;
    logic [7:0] r_warm_cnt;
    logic [7:0] w_warm_nxt;
    logic       r_pending;
    logic       w_pending_nxt;
    logic [1:0] r_mode_sel;
    logic [1:0] w_mode_nxt;
    logic       r_mode_bit;
    logic       r_color_3b;
    logic       r_out_en;
    logic       w_advance;
    logic       w_expire;

`ifdef DVI_SEQ_AUTO_EN
    logic [11:0] r_auto_cnt;
    logic [11:0] w_auto_nxt;

    assign w_expire = (r_state == ST_RUN) && r_frame_start && i_auto_en &&
                      (r_auto_cnt == 12'(AUTO_FRAMES - 1));

    // Counter only runs in RUN with auto enabled; any advance restarts the interval.
    always_comb begin
        w_auto_nxt = r_auto_cnt;
        if (!r_lock_s || (r_state != ST_RUN) || !i_auto_en || w_advance) begin
            w_auto_nxt = 12'd0;
        end else if (r_frame_start) begin
            w_auto_nxt = r_auto_cnt + 12'd1;
        end
    end

    always_ff @(posedge i_clk_dot or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_auto_cnt <= 12'd0;
        end else begin
            r_auto_cnt <= w_auto_nxt;
        end
    end
`else
    logic w_unused_auto_en;

    assign w_unused_auto_en = i_auto_en;
    assign w_expire         = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_warm_nxt    = r_warm_cnt;
        w_pending_nxt = r_pending;
        w_mode_nxt    = r_mode_sel;
        w_advance     = 1'b0;
        case (r_state)
            ST_OFF: begin
                w_warm_nxt    = 8'd0;
                w_pending_nxt = 1'b0;
                if (r_lock_s) begin
                    w_state_nxt = ST_WARM;
                end
            end
            ST_WARM: begin
                if (i_btn_step) begin
                    w_pending_nxt = 1'b1;
                end
                if (r_frame_start) begin
                    if (r_warm_cnt == 8'(WARMUP_FRAMES - 1)) begin
                        w_state_nxt = ST_RUN;
                        w_warm_nxt  = 8'd0;
                    end else begin
                        w_warm_nxt = r_warm_cnt + 8'd1;
                    end
                end
            end
            ST_RUN: begin
                if (i_btn_step) begin
                    w_pending_nxt = 1'b1;
                end
                // Step and timer expiry in the same frame collapse into one advance.
                w_advance = r_frame_start && (r_pending || i_btn_step || w_expire);
                if (w_advance) begin
                    w_pending_nxt = 1'b0;
                    w_mode_nxt    = (r_mode_sel == 2'(NUM_MODES - 1)) ? 2'd0 : r_mode_sel + 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
            end
        endcase
        if (!r_lock_s) begin
            w_state_nxt   = ST_OFF;
            w_warm_nxt    = 8'd0;
            w_pending_nxt = 1'b0;
            w_mode_nxt    = r_mode_sel;
            w_advance     = 1'b0;
        end
    end

    always_ff @(posedge i_clk_dot or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lock_m      <= 1'b0;
            r_lock_s      <= 1'b0;
            r_vs_q        <= 1'b0;
            r_frame_start <= 1'b0;
            r_state       <= ST_OFF;
            r_warm_cnt    <= 8'd0;
            r_pending     <= 1'b0;
            r_mode_sel    <= 2'd0;
            r_mode_bit    <= 1'b0;
            r_color_3b    <= 1'b0;
            r_out_en      <= 1'b0;
        end else begin
            r_lock_m      <= i_pll_lock;
            r_lock_s      <= r_lock_m;
            r_vs_q        <= i_vga_vs;
            r_frame_start <= i_vga_vs & ~r_vs_q;
            r_state       <= w_state_nxt;
            r_warm_cnt    <= w_warm_nxt;
            r_pending     <= w_pending_nxt;
            r_mode_sel    <= w_mode_nxt;
            r_mode_bit    <= w_mode_nxt[0];
            r_color_3b    <= w_mode_nxt[1];
            r_out_en      <= (w_state_nxt == ST_RUN);
        end
    end

    assign o_mode_sel  = r_mode_sel;
    assign o_mode_bit  = r_mode_bit;
    assign o_color_3b  = r_color_3b;
    assign o_out_en    = r_out_en;
    assign o_seq_state = r_state;

endmodule

// File: tb/tb_dvi_mode_sequencer.sv
// tb/tb_dvi_mode_sequencer.sv - directed checks of lock-up, stepping, wrap, lock loss and reset
module tb_dvi_mode_sequencer;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       lock    = 1'b0;
    logic       vs      = 1'b0;
    logic       btn     = 1'b0;
    logic       auto_en = 1'b0;
    logic [1:0] mode_sel;
    logic [1:0] seq_state;
    logic       mode_bit;
    logic       color_3b;
    logic       out_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dvi_mode_sequencer #(
        .WARMUP_FRAMES(4),
        .AUTO_FRAMES  (2),
        .NUM_MODES    (4)
    ) dut (
        .i_clk_dot  (clk),
        .i_reset_n  (rst_n),
        .i_pll_lock (lock),
        .i_vga_vs   (vs),
        .i_btn_step (btn),
        .i_auto_en  (auto_en),
        .o_mode_sel (mode_sel),
        .o_mode_bit (mode_bit),
        .o_color_3b (color_3b),
        .o_out_en   (out_en),
        .o_seq_state(seq_state)
    );

    typedef struct {
        logic       btn;
        logic       vs;
        logic [1:0] exp_mode;
    } vec_t;

    vec_t tbl [23];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] e_mode, input logic e_oe,
                           input logic [1:0] e_st);
        chk({tag, ".mode_sel"}, {6'd0, mode_sel}, {6'd0, e_mode});
        chk({tag, ".mode_bit"}, {7'd0, mode_bit}, {7'd0, e_mode[0]});
        chk({tag, ".color_3b"}, {7'd0, color_3b}, {7'd0, e_mode[1]});
        chk({tag, ".out_en"}, {7'd0, out_en}, {7'd0, e_oe});
        chk({tag, ".seq_state"}, {6'd0, seq_state}, {6'd0, e_st});
    endtask

    // vsync high for two cycles; optional step coincident with the registered frame start
    task automatic frame(input logic step_at_fs, input int gap);
        vs = 1'b1;
        tick(1);
        btn = step_at_fs;
        tick(1);
        btn = 1'b0;
        vs  = 1'b0;
        tick(gap);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 1'b0, 2'd0};
        tbl[3]  = '{1'b0, 1'b0, 2'd0};
        tbl[4]  = '{1'b1, 1'b0, 2'd0};
        tbl[5]  = '{1'b0, 1'b0, 2'd0};
        tbl[6]  = '{1'b0, 1'b1, 2'd0};
        tbl[7]  = '{1'b0, 1'b1, 2'd1};
        tbl[8]  = '{1'b0, 1'b0, 2'd1};
        tbl[9]  = '{1'b0, 1'b0, 2'd1};
        tbl[10] = '{1'b0, 1'b0, 2'd1};
        tbl[11] = '{1'b0, 1'b0, 2'd1};
        tbl[12] = '{1'b0, 1'b0, 2'd1};
        tbl[13] = '{1'b0, 1'b1, 2'd1};
        tbl[14] = '{1'b0, 1'b1, 2'd1};
        tbl[15] = '{1'b0, 1'b0, 2'd1};
        tbl[16] = '{1'b0, 1'b1, 2'd1};
        tbl[17] = '{1'b1, 1'b1, 2'd2};
        tbl[18] = '{1'b0, 1'b0, 2'd2};
        tbl[19] = '{1'b0, 1'b0, 2'd2};
        tbl[20] = '{1'b0, 1'b1, 2'd2};
        tbl[21] = '{1'b0, 1'b1, 2'd2};
        tbl[22] = '{1'b0, 1'b0, 2'd2};

        tick(3);
        chk_out("reset", 2'd0, 1'b0, 2'd0);
        rst_n = 1'b1;
        tick(7);

        lock = 1'b1;
        tick(2);
        chk_out("lock_sync", 2'd0, 1'b0, 2'd0);
        tick(1);
        chk_out("warm_entry", 2'd0, 1'b0, 2'd1);
        repeat (3) frame(1'b0, 4);
        chk_out("warm_3frames", 2'd0, 1'b0, 2'd1);
        vs = 1'b1;
        tick(1);
        chk_out("warm_4th_fs", 2'd0, 1'b0, 2'd1);
        tick(1);
        vs = 1'b0;
        chk_out("run_entry", 2'd0, 1'b1, 2'd2);
        tick(4);

        for (int i = 0; i < 23; i++) begin
            btn = tbl[i].btn;
            vs  = tbl[i].vs;
            tick(1);
            chk_out($sformatf("step_vec%0d", i), tbl[i].exp_mode, 1'b1, 2'd2);
        end
        btn = 1'b0;
        vs  = 1'b0;
        tick(2);

        lock = 1'b0;
        tick(2);
        chk_out("lockloss_2edges", 2'd2, 1'b1, 2'd2);
        tick(1);
        chk_out("lockloss_3edges", 2'd2, 1'b0, 2'd0);
        btn = 1'b1;
        tick(1);
        btn = 1'b0;
        repeat (2) frame(1'b0, 4);
        chk_out("off_step_dropped", 2'd2, 1'b0, 2'd0);

        lock = 1'b1;
        tick(3);
        chk_out("relock_warm", 2'd2, 1'b0, 2'd1);
        frame(1'b0, 4);
        btn = 1'b1;
        tick(1);
        btn = 1'b0;
        tick(1);
        repeat (2) frame(1'b0, 4);
        chk_out("relock_3frames", 2'd2, 1'b0, 2'd1);
        vs = 1'b1;
        tick(2);
        vs = 1'b0;
        chk_out("relock_run_no_adv", 2'd2, 1'b1, 2'd2);
        tick(4);
        frame(1'b0, 4);
        chk_out("warm_step_applied", 2'd3, 1'b1, 2'd2);

        auto_en = 1'b1;
        tick(1);
        frame(1'b0, 4);
        chk_out("auto_frame_a", 2'd3, 1'b1, 2'd2);
        frame(1'b1, 4);
        chk_out("wrap_single_adv", 2'd0, 1'b1, 2'd2);
        frame(1'b0, 4);
        chk_out("auto_cnt_cleared", 2'd0, 1'b1, 2'd2);
        frame(1'b0, 4);
`ifdef DVI_SEQ_AUTO_EN
        chk_out("auto_expiry", 2'd1, 1'b1, 2'd2);
        auto_en = 1'b0;
        repeat (3) frame(1'b0, 4);
        chk_out("auto_disabled", 2'd1, 1'b1, 2'd2);
`else
        chk_out("no_auto_expiry", 2'd0, 1'b1, 2'd2);
        repeat (1000) frame(1'b0, 3);
        chk_out("macro_off_1000", 2'd0, 1'b1, 2'd2);
        auto_en = 1'b0;
`endif

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_reset", 2'd0, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        chk_out("post_reset_off", 2'd0, 1'b0, 2'd0);
        tick(1);
        chk_out("post_reset_warm", 2'd0, 1'b0, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
